// File: rtl/vga_scan_pkg.sv
// Shared types and elaboration-time helpers for the vga_scan timing generator.
package vga_scan_pkg;

   typedef logic [23:0] rgb24_t;

   typedef struct packed {
      logic [31:0] sync_start;
      logic [31:0] sync_end;
   } sync_bounds_t;

   // Decoded beam attributes one enabled cycle behind the beam counters.
   typedef struct packed {
      logic   blank;
      logic   vblank;
      logic   hs;
      logic   vs;
      logic   frame;
      logic   use_lb;
      rgb24_t pix;
   } stage1_t;

   // Output register image: sync levels are already at pin polarity.
   typedef struct packed {
      rgb24_t rgb;
      logic   hsync;
      logic   vsync;
      logic   blank;
      logic   vblank;
      logic   frame;
   } out_stage_t;

   function automatic int calc_total(input int res, input int fp, input int pulse, input int bp);
      return res + fp + pulse + bp;
   endfunction

   function automatic sync_bounds_t calc_sync(input int res, input int fp, input int pulse);
      sync_bounds_t b;
      b.sync_start = 32'(res + fp);
      b.sync_end   = 32'(res + fp + pulse);
      return b;
   endfunction

   function automatic bit counter_fits(input int bits, input int total);
      return (64'd1 << bits) >= 64'(total);
   endfunction

endpackage

// File: rtl/vga_line_buffer.sv
// Simple dual-port line store used to replay a source line on the following
// beam line when vertical doubling is enabled.
module vga_line_buffer
   import vga_scan_pkg::*;
#(
   parameter int c_depth     = 320,
   parameter int c_addr_bits = 9
) (
   input  logic                   clk_pixel,
   input  logic                   ena,
   input  logic                   wr_en,
   input  logic [c_addr_bits-1:0] wr_addr,
   input  rgb24_t                 wr_data,
   input  logic                   rd_en,
   input  logic [c_addr_bits-1:0] rd_addr,
   output rgb24_t                 rd_data
);

   rgb24_t mem_q [c_depth];
   rgb24_t rd_data_q;

   // NOTE: storage and read register carry no reset; every odd line reads
   // only addresses written on the even line just before it.
   always_ff @(posedge clk_pixel) begin
      if (ena && wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (ena && rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_scan.sv
// VGA/DVI beam timing generator: counters, sync/blank decode, FIFO pixel
// fetch with optional X/Y doubling, test picture, fixed 2-cycle output lag.
module vga_scan
   import vga_scan_pkg::*;
#(
   parameter int c_resolution_x      = 640,
   parameter int c_hsync_front_porch = 16,
   parameter int c_hsync_pulse       = 96,
   parameter int c_hsync_back_porch  = 48,
   parameter int c_resolution_y      = 480,
   parameter int c_vsync_front_porch = 10,
   parameter int c_vsync_pulse       = 2,
   parameter int c_vsync_back_porch  = 33,
   parameter int c_bits_x            = 10,
   parameter int c_bits_y            = 10,
   parameter int c_hsync_pol         = 0,
   parameter int c_vsync_pol         = 0,
   parameter int c_dbl_x             = 0,
   parameter int c_dbl_y             = 0
) (
   input  logic                clk_pixel,
   input  logic                reset,
   input  logic                clk_pixel_ena,
   input  logic                test_picture,
   output logic                fetch_next,
   input  logic [7:0]          r_i,
   input  logic [7:0]          g_i,
   input  logic [7:0]          b_i,
   output logic [c_bits_x-1:0] beam_x,
   output logic [c_bits_y-1:0] beam_y,
   output logic [7:0]          vga_r,
   output logic [7:0]          vga_g,
   output logic [7:0]          vga_b,
   output logic                vga_hsync,
   output logic                vga_vsync,
   output logic                vga_blank,
   output logic                vga_vblank,
   output logic                vga_de,
   output logic                vga_frame
);

   localparam int c_total_x = calc_total(c_resolution_x, c_hsync_front_porch, c_hsync_pulse, c_hsync_back_porch);
   localparam int c_total_y = calc_total(c_resolution_y, c_vsync_front_porch, c_vsync_pulse, c_vsync_back_porch);
   localparam sync_bounds_t c_hb = calc_sync(c_resolution_x, c_hsync_front_porch, c_hsync_pulse);
   localparam sync_bounds_t c_vb = calc_sync(c_resolution_y, c_vsync_front_porch, c_vsync_pulse);

   localparam logic [c_bits_x-1:0] c_last_x   = c_bits_x'(c_total_x - 1);
   localparam logic [c_bits_y-1:0] c_last_y   = c_bits_y'(c_total_y - 1);
   localparam logic [c_bits_x-1:0] c_res_x    = c_bits_x'(c_resolution_x);
   localparam logic [c_bits_y-1:0] c_res_y    = c_bits_y'(c_resolution_y);
   localparam logic [c_bits_x-1:0] c_hs_start = c_bits_x'(c_hb.sync_start);
   localparam logic [c_bits_x-1:0] c_hs_end   = c_bits_x'(c_hb.sync_end);
   localparam logic [c_bits_y-1:0] c_vs_start = c_bits_y'(c_vb.sync_start);
   localparam logic [c_bits_y-1:0] c_vs_end   = c_bits_y'(c_vb.sync_end);
   localparam logic c_hs_on = (c_hsync_pol != 0);
   localparam logic c_vs_on = (c_vsync_pol != 0);

   localparam int c_lb_depth = c_resolution_x >> c_dbl_x;
   localparam int c_lb_aw    = (c_lb_depth > 1) ? $clog2(c_lb_depth) : 1;

   localparam stage1_t c_s1_rst = '{blank: 1'b1, vblank: 1'b1, hs: 1'b0, vs: 1'b0,
                                    frame: 1'b0, use_lb: 1'b0, pix: '0};
   localparam out_stage_t c_out_rst = '{rgb: '0, hsync: ~c_hs_on, vsync: ~c_vs_on,
                                        blank: 1'b1, vblank: 1'b1, frame: 1'b0};

   if (!counter_fits(c_bits_x, c_total_x) || !counter_fits(c_bits_y, c_total_y)) begin : g_bad_width
      $error("vga_scan: c_bits_x/c_bits_y cannot hold total_x-1/total_y-1");
   end

   logic [c_bits_x-1:0] beam_x_q, beam_x_d;
   logic [c_bits_y-1:0] beam_y_q, beam_y_d;
   logic                test_q, test_d;
   logic                fetch_q, fetch_d;
   stage1_t             s1_q, s1_d;
   out_stage_t          out_q, out_d;

   logic       at_last;
   logic       active;
   logic       src;
   logic       lb_read;
   logic [7:0] px;
   logic [7:0] py;
   rgb24_t     pattern;
   rgb24_t     fifo_rgb;
   rgb24_t     lb_rd_data;

   assign fifo_rgb = {r_i, g_i, b_i};

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      at_last = (beam_x_q == c_last_x) && (beam_y_q == c_last_y);
      active  = (beam_x_q < c_res_x) && (beam_y_q < c_res_y);
      src     = active && !test_q
                && ((c_dbl_x == 0) || !beam_x_q[0])
                && ((c_dbl_y == 0) || !beam_y_q[0]);
      lb_read = active && !test_q && (c_dbl_y != 0) && beam_y_q[0];
      px      = 8'(beam_x_q);
      py      = 8'(beam_y_q);
      pattern = {px, py, px ^ py};

      beam_x_d = beam_x_q;
      beam_y_d = beam_y_q;
      if (clk_pixel_ena) begin
         if (beam_x_q == c_last_x) begin
            beam_x_d = '0;
            beam_y_d = (beam_y_q == c_last_y) ? '0 : beam_y_q + 1'b1;
         end else begin
            beam_x_d = beam_x_q + 1'b1;
         end
      end

      // The test latch only moves on the last pixel of a frame so the FIFO
      // is never left with a partially consumed frame.
      test_d  = (clk_pixel_ena && at_last) ? test_picture : test_q;
      fetch_d = clk_pixel_ena && src;
   end

   always_comb begin
      s1_d = s1_q;
      if (clk_pixel_ena) begin
         s1_d.blank  = !active;
         s1_d.vblank = !(beam_y_q < c_res_y);
         s1_d.hs     = (beam_x_q >= c_hs_start) && (beam_x_q < c_hs_end);
         s1_d.vs     = (beam_y_q >= c_vs_start) && (beam_y_q < c_vs_end);
         s1_d.frame  = (beam_x_q == '0) && (beam_y_q == '0);
         s1_d.use_lb = lb_read;
         // Odd x in doubled mode keeps the previous sample in pix.
         if (test_q) begin
            s1_d.pix = pattern;
         end else if (src) begin
            s1_d.pix = fifo_rgb;
         end
      end
   end

   always_comb begin
      out_d = out_q;
      if (clk_pixel_ena) begin
         out_d.rgb    = s1_q.blank ? '0 : (s1_q.use_lb ? lb_rd_data : s1_q.pix);
         out_d.hsync  = s1_q.hs ? c_hs_on : ~c_hs_on;
         out_d.vsync  = s1_q.vs ? c_vs_on : ~c_vs_on;
         out_d.blank  = s1_q.blank;
         out_d.vblank = s1_q.vblank;
         out_d.frame  = s1_q.frame;
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         beam_x_q <= '0;
         beam_y_q <= '0;
         test_q   <= 1'b0;
         fetch_q  <= 1'b0;
         s1_q     <= c_s1_rst;
         out_q    <= c_out_rst;
      end else begin
         beam_x_q <= beam_x_d;
         beam_y_q <= beam_y_d;
         test_q   <= test_d;
         fetch_q  <= fetch_d;
         s1_q     <= s1_d;
         out_q    <= out_d;
      end
   end

   if (c_dbl_y != 0) begin : g_lb
      logic [c_lb_aw-1:0] lb_addr;
      assign lb_addr = c_lb_aw'(beam_x_q >> c_dbl_x);

      vga_line_buffer #(
         .c_depth    (c_lb_depth),
         .c_addr_bits(c_lb_aw)
      ) u_line_buffer (
         .clk_pixel(clk_pixel),
         .ena      (clk_pixel_ena),
         .wr_en    (src),
         .wr_addr  (lb_addr),
         .wr_data  (fifo_rgb),
         .rd_en    (lb_read),
         .rd_addr  (lb_addr),
         .rd_data  (lb_rd_data)
      );
   end else begin : g_no_lb
      assign lb_rd_data = '0;
   end

   assign fetch_next = fetch_q;
   assign beam_x     = beam_x_q;
   assign beam_y     = beam_y_q;
   assign vga_r      = out_q.rgb[23:16];
   assign vga_g      = out_q.rgb[15:8];
   assign vga_b      = out_q.rgb[7:0];
   assign vga_hsync  = out_q.hsync;
   assign vga_vsync  = out_q.vsync;
   assign vga_blank  = out_q.blank;
   assign vga_vblank = out_q.vblank;
   assign vga_de     = !out_q.blank;
   assign vga_frame  = out_q.frame;

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan on a reduced geometry: one plain instance and
// one doubled, inverted-polarity instance, both against a frame-level model.
module tb_vga_scan;

   localparam int RX = 16, HFP = 2, HPW = 3, HBP = 3;
   localparam int RY = 8,  VFP = 1, VPW = 2, VBP = 2;
   localparam int TX = RX + HFP + HPW + HBP;
   localparam int TY = RY + VFP + VPW + VBP;
   localparam int T  = TX * TY;
   localparam int BX = 5, BY = 4;
   localparam int NW = 4096;
   localparam int WPF_A = RX * RY;
   localparam int WPF_B = (RX / 2) * (RY / 2);
   localparam int NF = 256;

   typedef struct packed {
      logic [23:0] rgb;
      logic        hsync;
      logic        vsync;
      logic        blank;
      logic        vblank;
      logic        de;
      logic        frame;
   } out_t;

   typedef struct {
      int   bx;
      int   by;
      logic fetch_a;
      logic fetch_b;
      out_t oa;
      out_t ob;
   } item_t;

   logic clk_pixel = 1'b0;
   logic reset = 1'b1;
   logic ena = 1'b0;
   logic test_picture = 1'b0;

   logic [23:0] words [NW];
   int unsigned w_a = 0, w_b = 0;
   logic [23:0] rgb_a, rgb_b;
   assign rgb_a = words[w_a % NW];
   assign rgb_b = words[w_b % NW];

   logic          fetch_a, fetch_b;
   logic [BX-1:0] beam_x_a, beam_x_b;
   logic [BY-1:0] beam_y_a, beam_y_b;
   logic [7:0]    r_a, g_a, b_a, r_b, g_b, b_b;
   logic          hs_a, vs_a, bl_a, vbl_a, de_a, fr_a;
   logic          hs_b, vs_b, bl_b, vbl_b, de_b, fr_b;

   int n_cmp = 0;
   int n_bad = 0;

   item_t sb[$];
   int    e = 0;
   bit    test_f [NF];
   int    base_a [NF];
   int    base_b [NF];

   always #5 clk_pixel = ~clk_pixel;

   vga_scan #(
      .c_resolution_x(RX), .c_hsync_front_porch(HFP), .c_hsync_pulse(HPW), .c_hsync_back_porch(HBP),
      .c_resolution_y(RY), .c_vsync_front_porch(VFP), .c_vsync_pulse(VPW), .c_vsync_back_porch(VBP),
      .c_bits_x(BX), .c_bits_y(BY), .c_hsync_pol(0), .c_vsync_pol(0), .c_dbl_x(0), .c_dbl_y(0)
   ) dut_a (
      .clk_pixel(clk_pixel), .reset(reset), .clk_pixel_ena(ena), .test_picture(test_picture),
      .fetch_next(fetch_a), .r_i(rgb_a[23:16]), .g_i(rgb_a[15:8]), .b_i(rgb_a[7:0]),
      .beam_x(beam_x_a), .beam_y(beam_y_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
      .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank(bl_a), .vga_vblank(vbl_a),
      .vga_de(de_a), .vga_frame(fr_a)
   );

   vga_scan #(
      .c_resolution_x(RX), .c_hsync_front_porch(HFP), .c_hsync_pulse(HPW), .c_hsync_back_porch(HBP),
      .c_resolution_y(RY), .c_vsync_front_porch(VFP), .c_vsync_pulse(VPW), .c_vsync_back_porch(VBP),
      .c_bits_x(BX), .c_bits_y(BY), .c_hsync_pol(1), .c_vsync_pol(1), .c_dbl_x(1), .c_dbl_y(1)
   ) dut_b (
      .clk_pixel(clk_pixel), .reset(reset), .clk_pixel_ena(ena), .test_picture(test_picture),
      .fetch_next(fetch_b), .r_i(rgb_b[23:16]), .g_i(rgb_b[15:8]), .b_i(rgb_b[7:0]),
      .beam_x(beam_x_b), .beam_y(beam_y_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
      .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank(bl_b), .vga_vblank(vbl_b),
      .vga_de(de_b), .vga_frame(fr_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   function automatic out_t reset_out(input bit pol);
      out_t o;
      o.rgb = '0; o.hsync = !pol; o.vsync = !pol;
      o.blank = 1'b1; o.vblank = 1'b1; o.de = 1'b0; o.frame = 1'b0;
      return o;
   endfunction

   // Position q counts enabled cycles since reset; frame f = q / T.
   function automatic bit is_src(input int q, input bit dx, input bit dy);
      int f, p, x, y;
      f = (q / T) % NF; p = q % T; x = p % TX; y = p / TX;
      return (x < RX) && (y < RY) && !test_f[f] && (!dx || (x % 2 == 0)) && (!dy || (y % 2 == 0));
   endfunction

   function automatic out_t model_out(input int q, input bit dx, input bit dy, input bit pol, input bit use_b);
      out_t o;
      int f, p, x, y, idx;
      bit active, hs, vs;
      f = (q / T) % NF; p = q % T; x = p % TX; y = p / TX;
      active = (x < RX) && (y < RY);
      hs = (x >= RX + HFP) && (x < RX + HFP + HPW);
      vs = (y >= RY + VFP) && (y < RY + VFP + VPW);
      o.blank = !active; o.de = active; o.vblank = (y >= RY);
      o.hsync = hs ? pol : !pol;
      o.vsync = vs ? pol : !pol;
      o.frame = (p == 0);
      if (!active) o.rgb = '0;
      else if (test_f[f]) o.rgb = {8'(x), 8'(y), 8'(x) ^ 8'(y)};
      else begin
         idx = (use_b ? base_b[f] : base_a[f]) + (y >> dy) * (RX >> dx) + (x >> dx);
         o.rgb = words[idx % NW];
      end
      return o;
   endfunction

   // Stimulus-side model: one expected item per clock after reset.
   always @(posedge clk_pixel) begin
      item_t it;
      int f;
      if (reset) begin
         e = 0;
         test_f[0] = 1'b0;
         base_a[0] = int'(w_a);
         base_b[0] = int'(w_b);
      end else begin
         it.fetch_a = 1'b0;
         it.fetch_b = 1'b0;
         if (ena) begin
            it.fetch_a = is_src(e, 1'b0, 1'b0);
            it.fetch_b = is_src(e, 1'b1, 1'b1);
            if (e % T == T - 1) begin
               f = ((e + 1) / T) % NF;
               test_f[f] = test_picture;
               base_a[f] = base_a[(f + NF - 1) % NF] + (test_f[(f + NF - 1) % NF] ? 0 : WPF_A);
               base_b[f] = base_b[(f + NF - 1) % NF] + (test_f[(f + NF - 1) % NF] ? 0 : WPF_B);
            end
            e++;
         end
         it.bx = (e % T) % TX;
         it.by = (e % T) / TX;
         it.oa = (e >= 2) ? model_out(e - 2, 1'b0, 1'b0, 1'b0, 1'b0) : reset_out(1'b0);
         it.ob = (e >= 2) ? model_out(e - 2, 1'b1, 1'b1, 1'b1, 1'b1) : reset_out(1'b1);
         sb.push_back(it);
      end
   end

   // FIFO: the next word is presented as soon as fetch_next is seen.
   always @(posedge clk_pixel) begin
      #1;
      if (fetch_a) w_a++;
      if (fetch_b) w_b++;
   end

   // Monitor: the DUT presents a new output state every clock out of reset.
   always @(posedge clk_pixel) begin
      item_t it;
      out_t act_a, act_b;
      #1;
      if (!reset && sb.size() > 0) begin
         it = sb.pop_front();
         act_a = {r_a, g_a, b_a, hs_a, vs_a, bl_a, vbl_a, de_a, fr_a};
         act_b = {r_b, g_b, b_b, hs_b, vs_b, bl_b, vbl_b, de_b, fr_b};
         check("a.beam_x", beam_x_a, it.bx);
         check("a.beam_y", beam_y_a, it.by);
         check("b.beam_x", beam_x_b, it.bx);
         check("b.beam_y", beam_y_b, it.by);
         check("a.fetch_next", fetch_a, it.fetch_a);
         check("b.fetch_next", fetch_b, it.fetch_b);
         check("a.outputs", act_a, it.oa);
         check("b.outputs", act_b, it.ob);
      end
   end

   task automatic check_reset_state(input string tag);
      out_t act_a, act_b;
      act_a = {r_a, g_a, b_a, hs_a, vs_a, bl_a, vbl_a, de_a, fr_a};
      act_b = {r_b, g_b, b_b, hs_b, vs_b, bl_b, vbl_b, de_b, fr_b};
      check({tag, ".a.beam"}, {beam_x_a, beam_y_a}, '0);
      check({tag, ".b.beam"}, {beam_x_b, beam_y_b}, '0);
      check({tag, ".a.fetch"}, fetch_a, 1'b0);
      check({tag, ".b.fetch"}, fetch_b, 1'b0);
      check({tag, ".a.outputs"}, act_a, reset_out(1'b0));
      check({tag, ".b.outputs"}, act_b, reset_out(1'b1));
   endtask

   task automatic wait_beam(input int x, input int y);
      int n;
      n = 0;
      while (!(int'(beam_x_a) == x && int'(beam_y_a) == y)) begin
         if (n >= 4 * T) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_beam(%0d,%0d): beam stuck at (%0d,%0d)", x, y, beam_x_a, beam_y_a);
            return;
         end
         @(negedge clk_pixel);
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NW; i++) words[i] = 24'($urandom);
      repeat (3) @(negedge clk_pixel);
      check_reset_state("por");
      reset = 1'b0;
      ena   = 1'b1;
      repeat (2 * T + 7) @(negedge clk_pixel);

      // Advance enable 1 of 3 clocks: outputs hold, fetch only after enabled edges.
      for (int i = 0; i < 3 * T; i++) begin
         ena = (i % 3 == 0);
         @(negedge clk_pixel);
      end
      ena = 1'b1;

      // Test picture requested mid-frame takes effect at the next frame.
      wait_beam(0, 3);
      test_picture = 1'b1;
      wait_beam(0, 0);
      wait_beam(7, 3);
      check("test.rgb@(5,3)", {r_a, g_a, b_a}, 24'h050306);
      check("test.de@(5,3)", de_a, 1'b1);
      test_picture = 1'b0;
      repeat (T + 20) @(negedge clk_pixel);

      // Random enable with occasional test_picture changes at any point.
      for (int i = 0; i < 4 * T; i++) begin
         ena = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 40) == 0) test_picture = 1'($urandom_range(0, 1));
         @(negedge clk_pixel);
      end
      ena = 1'b1;
      test_picture = 1'b0;
      repeat (T) @(negedge clk_pixel);

      // Asynchronous reset mid-line; state must clear without a clock edge.
      wait_beam(10, 2);
      reset = 1'b1;
      #1;
      check_reset_state("midline");
      repeat (2) @(negedge clk_pixel);
      reset = 1'b0;
      repeat (T + 20) @(negedge clk_pixel);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
